// File: rtl/cory_yuv2rgb.sv
// cory_yuv2rgb: studio-range BT.601 {Y,U,V} to full-range {R,G,B}, 3-stage elastic pipeline, 1 pixel/clk.
// Latency: 3 cycles input-to-output; backpressure: stages fill while i_z_r is low, o_a_r drops once all 3 are full.
// Optional CORY_YUV2RGB_SAT_CNT_EN adds o_sat_cnt, a saturating count of output pixels that were clamped.
module cory_yuv2rgb #(
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_a_v,
    input  logic [23:0] i_a_d,
    output logic        o_a_r,
    output logic        o_z_v,
    output logic [23:0] o_z_d,
    input  logic        i_z_r
`ifdef CORY_YUV2RGB_SAT_CNT_EN
    ,
    output logic [15:0] o_sat_cnt
`endif
);

    localparam logic signed [19:0] K = (ROUND != 0) ? 20'sd128 : 20'sd0;

    logic en1, en2, en3;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [9:0]  c_q, c_d, d_q, d_d, e_q, e_d;
    logic signed [19:0] c_x, d_x, e_x;
    logic signed [19:0] r_sum_q, r_sum_d, g_sum_q, g_sum_d, b_sum_q, b_sum_d;
    logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
`ifdef CORY_YUV2RGB_SAT_CNT_EN
    logic               sat_q, sat_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;
`endif

    // Arithmetic shift then clamp to 0..255; over-range shows up in any bit above bit 7.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic signed [19:0] t;
        t = s >>> 8;
        if (t[19])
            return 8'h00;
        else if (|t[18:8])
            return 8'hFF;
        else
            return t[7:0];
    endfunction

    function automatic logic clamped(input logic signed [19:0] s);
        logic signed [19:0] t;
        t = s >>> 8;
        return t[19] | (|t[18:8]);
    endfunction

    assign c_x = {{10{c_q[9]}}, c_q};
    assign d_x = {{10{d_q[9]}}, d_q};
    assign e_x = {{10{e_q[9]}}, e_q};

    // A stage loads when it is empty or its contents leave this cycle; bubbles collapse.
    always_comb begin
        en3  = !v3_q || i_z_r;
        en2  = !v2_q || en3;
        en1  = !v1_q || en2;
        v1_d = en1 ? i_a_v : v1_q;
        v2_d = en2 ? v1_q  : v2_q;
        v3_d = en3 ? v2_q  : v3_q;
    end

    always_comb begin
        c_d = c_q;
        d_d = d_q;
        e_d = e_q;
        if (en1 && i_a_v) begin
            c_d = $signed({2'b00, i_a_d[23:16]}) - 10'sd16;
            d_d = $signed({2'b00, i_a_d[15:8]})  - 10'sd128;
            e_d = $signed({2'b00, i_a_d[7:0]})   - 10'sd128;
        end
    end

    always_comb begin
        r_sum_d = r_sum_q;
        g_sum_d = g_sum_q;
        b_sum_d = b_sum_q;
        if (en2 && v1_q) begin
            r_sum_d = c_x * 20'sd298 + e_x * 20'sd409 + K;
            g_sum_d = c_x * 20'sd298 - d_x * 20'sd100 - e_x * 20'sd208 + K;
            b_sum_d = c_x * 20'sd298 + d_x * 20'sd516 + K;
        end
    end

    // Output data only changes when a new pixel lands, so o_z_d holds across bubbles and stalls.
    always_comb begin
        r_d = r_q;
        g_d = g_q;
        b_d = b_q;
`ifdef CORY_YUV2RGB_SAT_CNT_EN
        sat_d = sat_q;
`endif
        if (en3 && v2_q) begin
            r_d = clamp8(r_sum_q);
            g_d = clamp8(g_sum_q);
            b_d = clamp8(b_sum_q);
`ifdef CORY_YUV2RGB_SAT_CNT_EN
            sat_d = clamped(r_sum_q) | clamped(g_sum_q) | clamped(b_sum_q);
`endif
        end
    end

`ifdef CORY_YUV2RGB_SAT_CNT_EN
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (v3_q && i_z_r && sat_q && (sat_cnt_q != 16'hFFFF))
            sat_cnt_d = sat_cnt_q + 16'd1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            r_sum_q <= '0;
            g_sum_q <= '0;
            b_sum_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            r_sum_q <= r_sum_d;
            g_sum_q <= g_sum_d;
            b_sum_q <= b_sum_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

`ifdef CORY_YUV2RGB_SAT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

    assign o_a_r = en1;
    assign o_z_v = v3_q;
    assign o_z_d = {r_q, g_q, b_q};

endmodule

// File: tb/tb_cory_yuv2rgb.sv
// Bench for cory_yuv2rgb: directed vectors plus a scoreboarded random stream, run against ROUND=1 and ROUND=0 instances.
module tb_cory_yuv2rgb;

    logic        clk;
    logic        reset_n;
    logic        i_a_v;
    logic [23:0] i_a_d;
    logic        i_z_r;
    logic        o_a_r, o_z_v;
    logic [23:0] o_z_d;
    logic        o0_a_r, o0_z_v;
    logic [23:0] o0_z_d;
`ifdef CORY_YUV2RGB_SAT_CNT_EN
    logic [15:0] o_sat_cnt, o0_sat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    logic [47:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [23:0] held_d = '0;

    cory_yuv2rgb #(.ROUND(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
        .o_z_v(o_z_v), .o_z_d(o_z_d), .i_z_r(i_z_r)
`ifdef CORY_YUV2RGB_SAT_CNT_EN
        , .o_sat_cnt(o_sat_cnt)
`endif
    );

    cory_yuv2rgb #(.ROUND(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o0_a_r),
        .o_z_v(o0_z_v), .o_z_d(o0_z_d), .i_z_r(i_z_r)
`ifdef CORY_YUV2RGB_SAT_CNT_EN
        , .o_sat_cnt(o0_sat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] d, input int rnd);
        int c, dd, e, k, t;
        int s[3];
        logic [23:0] res;
        c  = int'(d[23:16]) - 16;
        dd = int'(d[15:8]) - 128;
        e  = int'(d[7:0]) - 128;
        k  = (rnd != 0) ? 128 : 0;
        s[0] = 298 * c + 409 * e + k;
        s[1] = 298 * c - 100 * dd - 208 * e + k;
        s[2] = 298 * c + 516 * dd + k;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            t = s[i] >>> 8;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            res[23 - 8 * i -: 8] = 8'(t);
        end
        return res;
    endfunction

    // Scoreboard: every input transfer predicts an output; stalled outputs must hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_v", 32'(o_z_v), 32'd1);
                check("hold_d", 32'(o_z_d), 32'(held_d));
            end
            if (o_z_v && i_z_r) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    check("sb_pix", 32'(o_z_d), 32'(e[23:0]));
                    check("sb_pix_r0", 32'(o0_z_d), 32'(e[47:24]));
                end
            end
            stall_prev = o_z_v && !i_z_r;
            held_d     = o_z_d;
            if (i_a_v && o_a_r) begin
                exp_q.push_back({model(i_a_d, 0), model(i_a_d, 1)});
                n_in++;
            end
        end
    end

    task automatic send_one(input string tag, input logic [23:0] d, input logic [23:0] exp1,
                            input logic [23:0] exp0, input int exp_sat);
        int lat;
        logic [15:0] sb;
        sb = '0;
        @(posedge clk); #1;
        i_a_v = 1'b1;
        i_a_d = d;
        i_z_r = 1'b1;
`ifdef CORY_YUV2RGB_SAT_CNT_EN
        sb = o_sat_cnt;
`endif
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (o_z_v) break;
            @(posedge clk); #1;
            i_a_v = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_d"}, 32'(o_z_d), 32'(exp1));
        check({tag, "_d_r0"}, 32'(o0_z_d), 32'(exp0));
        @(posedge clk); #1;
`ifdef CORY_YUV2RGB_SAT_CNT_EN
        check({tag, "_sat"}, 32'(o_sat_cnt), 32'(sb) + 32'(exp_sat));
`else
        check({tag, "_empty"}, 32'(o_z_v), 32'(exp_sat) & 32'd0);
`endif
    endtask

    initial begin
        int acc, ar_low, zv_low, cyc;
        reset_n = 1'b0;
        i_a_v   = 1'b0;
        i_a_d   = '0;
        i_z_r   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_z_v", 32'(o_z_v), 32'd0);
        check("rst_z_d", 32'(o_z_d), 32'd0);
        check("rst_a_r", 32'(o_a_r), 32'd1);
`ifdef CORY_YUV2RGB_SAT_CNT_EN
        check("rst_sat", 32'(o_sat_cnt), 32'd0);
`endif
        @(posedge clk); #3;
        reset_n = 1'b1;

        send_one("black", 24'h108080, 24'h000000, 24'h000000, 0);
        send_one("white", 24'hEB8080, 24'hFFFFFF, 24'hFEFEFE, 0);
        send_one("mid",   24'h8064C8, 24'hF5534A, 24'hF55249, 0);
        send_one("max",   24'hFFFFFF, 24'hFF7DFF, 24'hFF7DFF, 1);
        send_one("zero",  24'h000000, 24'h008700, 24'h008700, 1);

        // Stall depth: exactly three accepts with the sink blocked.
        @(posedge clk); #1;
        i_z_r = 1'b0;
        i_a_v = 1'b1;
        i_a_d = $urandom;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_a_r) acc++;
            @(posedge clk); #1;
            i_a_d = $urandom;
        end
        check("stall_accepts", 32'(acc), 32'd3);
        check("stall_a_r", 32'(o_a_r), 32'd0);
        i_z_r = 1'b1;
        @(negedge clk);
        check("full_thru_a_r", 32'(o_a_r), 32'd1);
        check("full_thru_z_v", 32'(o_z_v), 32'd1);
        @(posedge clk); #1;
        i_a_v = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back with the sink always ready.
        i_a_v = 1'b1;
        ar_low = 0;
        zv_low = 0;
        for (int i = 0; i < 40; i++) begin
            i_a_d = $urandom;
            @(negedge clk);
            if (!o_a_r) ar_low++;
            if (i >= 3 && !o_z_v) zv_low++;
            @(posedge clk); #1;
        end
        check("b2b_a_r_low", 32'(ar_low), 32'd0);
        check("b2b_z_v_gaps", 32'(zv_low), 32'd0);
        i_a_v = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Random stream with random valid and ready.
        n_in = 0;
        cyc = 0;
        while (n_in < 10000 && cyc < 60000) begin
            i_a_v = ($urandom_range(0, 3) != 0);
            i_a_d = $urandom;
            i_z_r = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_sent", 32'(n_in), 32'd10000);
        i_a_v = 1'b0;
        i_z_r = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with a full pipeline.
        i_z_r = 1'b0;
        i_a_v = 1'b1;
        repeat (4) begin
            i_a_d = $urandom;
            @(posedge clk); #1;
        end
        i_a_v = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_z_v", 32'(o_z_v), 32'd0);
        check("mid_rst_z_d", 32'(o_z_d), 32'd0);
        check("mid_rst_a_r", 32'(o_a_r), 32'd1);
        @(posedge clk); #3;
        reset_n = 1'b1;
        send_one("post_rst", 24'hEB8080, 24'hFFFFFF, 24'hFEFEFE, 0);
        repeat (4) @(posedge clk);
        #1;
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
